// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter giving N requesters write access to one shared k-bit
// load-enabled register. A winner's lane is latched onto din with a one-cycle
// load/gnt pulse; back-to-back grants go to a different requester.
module reg_write_arbiter #(
   parameter int unsigned k = 16,
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*k-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [k-1:0]   din,
   output logic           load,
   output logic           busy
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state;
   logic [PW-1:0] ptr;

   logic [k-1:0]  lanes [N];
   logic [N-1:0]  cand_c;
   logic          found_c;
   logic [PW-1:0] win_c;
   logic [PW-1:0] nxt_c;

   // Split the flat write bus into per-requester lanes.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         lanes[i] = wdata[i*k +: k];
      end
   end

   // Pick the first pending request at or after ptr; the requester being
   // granted right now is masked so its still-high req is not re-served.
   always_comb begin
      cand_c  = req & ~gnt;
      found_c = 1'b0;
      win_c   = '0;
      for (int unsigned off = 0; off < N; off++) begin
         if (!found_c && cand_c[PW'((32'(ptr) + off) % N)]) begin
            found_c = 1'b1;
            win_c   = PW'((32'(ptr) + off) % N);
         end
      end
      nxt_c = PW'((32'(win_c) + 32'd1) % N);
   end

   // Grant state machine with registered outputs; din holds between grants.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
         din   <= '0;
         load  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found_c) begin
                  state <= GRANT;
                  gnt   <= N'(1) << win_c;
                  din   <= lanes[win_c];
                  load  <= 1'b1;
                  busy  <= 1'b1;
                  ptr   <= nxt_c;
               end else begin
                  gnt   <= '0;
                  load  <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            GRANT: begin
               if (found_c) begin
                  gnt   <= N'(1) << win_c;
                  din   <= lanes[win_c];
                  load  <= 1'b1;
                  busy  <= 1'b1;
                  ptr   <= nxt_c;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
                  load  <= 1'b0;
                  busy  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, hand-written reset and
// timing sequences, then randomized requesters checked against a model.
module tb_reg_write_arbiter;

   localparam int unsigned K = 16;
   localparam int unsigned N = 4;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*K-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [K-1:0]   din;
   logic           load;
   logic           busy;

   int n_vec;
   int n_err;

   reg_write_arbiter #(.k(K), .N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .din   (din),
      .load  (load),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic [K-1:0] din;
      logic         load;
      logic         busy;
   } vec_t;

   typedef struct {
      logic [N-1:0] gnt;
      logic [K-1:0] din;
      logic         load;
      logic         busy;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   int           m_ptr;
   int           m_last;
   logic [K-1:0] m_din;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b0;
      m_ptr  = 0;
      m_last = -1;
      m_din  = '0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Predict outputs after the next edge from the inputs just driven.
   task automatic model_step();
      exp_t e;
      int   w;
      w = -1;
      for (int s = 0; s < int'(N); s++) begin
         int i;
         i = (m_ptr + s) % int'(N);
         if (w < 0 && req[i] && i != m_last) w = i;
      end
      if (w >= 0) begin
         m_din  = wdata[w*K +: K];
         m_ptr  = (w + 1) % int'(N);
         m_last = w;
         e.gnt  = N'(1) << w;
         e.load = 1'b1;
         e.busy = 1'b1;
      end else begin
         m_last = -1;
         e.gnt  = '0;
         e.load = 1'b0;
         e.busy = 1'b0;
      end
      e.din = m_din;
      exp_q.push_back(e);
   endtask

   initial begin
      vec_t         tbl [16];
      logic [N-1:0] seq [5];
      logic         pend  [N];
      logic [K-1:0] ldata [N];
      int           waitc [N];
      exp_t         e;
      logic [N-1:0] g;

      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      req   = '0;
      wdata = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};

      tbl[0]  = '{4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{4'b0100, 4'b0100, 16'hBEEF, 1'b1, 1'b1};
      tbl[2]  = '{4'b0000, 4'b0000, 16'hBEEF, 1'b0, 1'b0};
      tbl[3]  = '{4'b0011, 4'b0001, 16'h1111, 1'b1, 1'b1};
      tbl[4]  = '{4'b0011, 4'b0010, 16'h2222, 1'b1, 1'b1};
      tbl[5]  = '{4'b0010, 4'b0000, 16'h2222, 1'b0, 1'b0};
      tbl[6]  = '{4'b1111, 4'b0100, 16'hBEEF, 1'b1, 1'b1};
      tbl[7]  = '{4'b1111, 4'b1000, 16'h4444, 1'b1, 1'b1};
      tbl[8]  = '{4'b1111, 4'b0001, 16'h1111, 1'b1, 1'b1};
      tbl[9]  = '{4'b1111, 4'b0010, 16'h2222, 1'b1, 1'b1};
      tbl[10] = '{4'b1111, 4'b0100, 16'hBEEF, 1'b1, 1'b1};
      tbl[11] = '{4'b0000, 4'b0000, 16'hBEEF, 1'b0, 1'b0};
      tbl[12] = '{4'b1000, 4'b1000, 16'h4444, 1'b1, 1'b1};
      tbl[13] = '{4'b1000, 4'b0000, 16'h4444, 1'b0, 1'b0};
      tbl[14] = '{4'b1000, 4'b1000, 16'h4444, 1'b1, 1'b1};
      tbl[15] = '{4'b0000, 4'b0000, 16'h4444, 1'b0, 1'b0};

      // reset state
      #2;
      chk("reset_gnt",  32'(gnt),  32'd0);
      chk("reset_load", 32'(load), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_din",  32'(din),  32'd0);
      do_reset();

      // directed vectors: single grant, wrap search, rotation, lone re-request
      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         req = tbl[v].req;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_gnt", v),  32'(gnt),  32'(tbl[v].gnt));
         chk($sformatf("tbl%0d_din", v),  32'(din),  32'(tbl[v].din));
         chk($sformatf("tbl%0d_load", v), 32'(load), 32'(tbl[v].load));
         chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      end

      // all requesting from reset: strict rotation with load held high
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      req = 4'b1111;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rot%0d_gnt", c),  32'(gnt),  32'(seq[c]));
         chk($sformatf("rot%0d_load", c), 32'(load), 32'd1);
      end

      // reset asserted mid-grant drops outputs at once and clears ptr
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_gnt",  32'(gnt),  32'd0);
      chk("midrst_load", 32'(load), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_din",  32'(din),  32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst_gnt", 32'(gnt), 32'h1);

      // request withdrawn before the sampling edge is never granted
      @(negedge clk);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      req = 4'b0010;
      #2;
      req = 4'b0000;
      @(posedge clk);
      #1;
      chk("pulse_gnt",  32'(gnt),  32'd0);
      chk("pulse_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("pulse_gnt2", 32'(gnt), 32'd0);

      // randomized requesters obeying the handshake, checked against the model
      for (int i = 0; i < int'(N); i++) begin
         pend[i]  = 1'b0;
         ldata[i] = '0;
         waitc[i] = 0;
      end
      req = '0;
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_gnt",  32'(gnt),  32'(e.gnt));
            chk("sb_din",  32'(din),  32'(e.din));
            chk("sb_load", 32'(load), 32'(e.load));
            chk("sb_busy", 32'(busy), 32'(e.busy));
         end
         chk("onehot0", 32'($onehot0(gnt)), 32'd1);
         chk("load_eq_gnt", 32'(load), 32'(|gnt));
         g = gnt;
         for (int i = 0; i < int'(N); i++) begin
            if (g[i]) begin
               chk($sformatf("fair%0d", i), 32'(waitc[i] <= int'(N)), 32'd1);
               chk($sformatf("lane%0d", i), 32'(din), 32'(ldata[i]));
               waitc[i] = 0;
               if ($urandom_range(0, 1) == 0) begin
                  ldata[i] = K'($urandom);
               end else begin
                  pend[i] = 1'b0;
               end
            end else if (pend[i]) begin
               if (g != '0) waitc[i]++;
            end else if ($urandom_range(0, 2) == 0) begin
               pend[i]  = 1'b1;
               ldata[i] = K'($urandom);
               waitc[i] = 0;
            end
         end
         for (int i = 0; i < int'(N); i++) begin
            req[i] = pend[i];
            wdata[i*K +: K] = pend[i] ? ldata[i] : K'($urandom);
         end
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
